// File: rtl/dtm_dmi_access_ctrl.sv
// rtl/dtm_dmi_access_ctrl.sv - JTAG DTM to DMI request/response access controller
// Optional response watchdog: define DTM_DMI_TIMEOUT_EN.
module dtm_dmi_access_ctrl #(
    parameter int ABITS   = 7,
    parameter int DBITS   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_update,
    input  logic [ABITS-1:0] io_update_addr,
    input  logic [DBITS-1:0] io_update_data,
    input  logic [1:0]       io_update_op,
    input  logic             io_capture,
    input  logic             io_dmireset,
    input  logic             io_dmihardreset,
    output logic [ABITS-1:0] io_capture_addr,
    output logic [DBITS-1:0] io_capture_data,
    output logic [1:0]       io_capture_op,
    output logic             io_dmi_req_valid,
    input  logic             io_dmi_req_ready,
    output logic [ABITS-1:0] io_dmi_req_addr,
    output logic [DBITS-1:0] io_dmi_req_data,
    output logic [1:0]       io_dmi_req_op,
    input  logic             io_dmi_resp_valid,
    output logic             io_dmi_resp_ready,
    input  logic [DBITS-1:0] io_dmi_resp_data,
    input  logic [1:0]       io_dmi_resp_resp,
    output logic             io_busy,
    output logic [1:0]       io_sticky_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_FAIL = 2'd2;
    localparam logic [1:0] ERR_BUSY = 2'd3;

    state_t           state, state_nxt;
    logic [1:0]       sticky_err, sticky_nxt;
    logic             drop_pending, drop_nxt;
    logic [ABITS-1:0] req_addr, req_addr_nxt;
    logic [DBITS-1:0] req_data, req_data_nxt;
    logic [1:0]       req_op, req_op_nxt;
    logic [DBITS-1:0] resp_data, resp_data_nxt;
    logic [ABITS-1:0] cap_addr, cap_addr_nxt;
    logic [DBITS-1:0] cap_data, cap_data_nxt;
    logic [1:0]       cap_op, cap_op_nxt;
    logic [1:0]       eff_sticky;
    logic             busy;
    logic             resp_ready;
    logic             timeout_hit;

`ifdef DTM_DMI_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] resp_cnt;

    // Counter only runs in RESP and is cleared everywhere else, so entry always starts at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_cnt <= '0;
        end else if (state != RESP) begin
            resp_cnt <= '0;
        end else begin
            resp_cnt <= resp_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == RESP) && (resp_cnt == CW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign busy       = (state != IDLE);
    assign resp_ready = (state == RESP) || drop_pending;
    assign eff_sticky = io_dmireset ? ERR_NONE : sticky_err;

    always_comb begin
        state_nxt     = state;
        sticky_nxt    = eff_sticky;
        drop_nxt      = drop_pending;
        req_addr_nxt  = req_addr;
        req_data_nxt  = req_data;
        req_op_nxt    = req_op;
        resp_data_nxt = resp_data;
        cap_addr_nxt  = cap_addr;
        cap_data_nxt  = cap_data;
        cap_op_nxt    = cap_op;

        // A stale response owed from an abandoned access is swallowed before any new one.
        if (drop_pending && io_dmi_resp_valid) begin
            drop_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (io_update && !io_dmihardreset && eff_sticky == ERR_NONE &&
                    (io_update_op == OP_READ || io_update_op == OP_WRITE)) begin
                    req_addr_nxt = io_update_addr;
                    req_data_nxt = io_update_data;
                    req_op_nxt   = io_update_op;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                if (io_dmi_req_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (io_dmi_resp_valid && !drop_pending) begin
                    if (req_op == OP_READ) begin
                        resp_data_nxt = io_dmi_resp_data;
                    end
                    if (io_dmi_resp_resp != 2'd0 && eff_sticky != ERR_BUSY) begin
                        sticky_nxt = ERR_FAIL;
                    end
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    if (eff_sticky != ERR_BUSY) begin
                        sticky_nxt = ERR_FAIL;
                    end
                    drop_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (busy && (io_update || io_capture)) begin
            sticky_nxt = ERR_BUSY;
        end

        // Capture reflects status as it stood before anything else in this cycle.
        if (io_capture) begin
            cap_addr_nxt = req_addr;
            cap_data_nxt = resp_data;
            if (busy || sticky_err == ERR_BUSY) begin
                cap_op_nxt = ERR_BUSY;
            end else if (sticky_err == ERR_FAIL) begin
                cap_op_nxt = ERR_FAIL;
            end else begin
                cap_op_nxt = ERR_NONE;
            end
        end

        if (io_dmihardreset) begin
            sticky_nxt    = ERR_NONE;
            resp_data_nxt = resp_data;
            if (state != IDLE) begin
                state_nxt = IDLE;
            end
            // A response arriving in this very cycle is consumed, so nothing more is owed.
            if (state == RESP) begin
                drop_nxt = drop_pending || !io_dmi_resp_valid;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sticky_err   <= ERR_NONE;
            drop_pending <= 1'b0;
            req_addr     <= '0;
            req_data     <= '0;
            req_op       <= 2'd0;
            resp_data    <= '0;
            cap_addr     <= '0;
            cap_data     <= '0;
            cap_op       <= 2'd0;
        end else begin
            state        <= state_nxt;
            sticky_err   <= sticky_nxt;
            drop_pending <= drop_nxt;
            req_addr     <= req_addr_nxt;
            req_data     <= req_data_nxt;
            req_op       <= req_op_nxt;
            resp_data    <= resp_data_nxt;
            cap_addr     <= cap_addr_nxt;
            cap_data     <= cap_data_nxt;
            cap_op       <= cap_op_nxt;
        end
    end

    assign io_dmi_req_valid  = (state == REQ);
    assign io_dmi_req_addr   = req_addr;
    assign io_dmi_req_data   = req_data;
    assign io_dmi_req_op     = req_op;
    assign io_dmi_resp_ready = resp_ready;
    assign io_capture_addr   = cap_addr;
    assign io_capture_data   = cap_data;
    assign io_capture_op     = cap_op;
    assign io_busy           = busy;
    assign io_sticky_err     = sticky_err;

endmodule
